// File: rtl/sigma_delta_mash_param.sv
// Run-time selectable MASH 1-1-1 sigma-delta modulator (order 1..STAGES) with LFSR dither on stage 1.
// Latency: sd_out/carry_mon register on the same edge as the accumulators; kin_ready low only during FLUSH.
module sigma_delta_mash_param #(
  parameter int          BITWIDTH  = 40,
  parameter int          STAGES    = 3,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic [1:0]             order_sel,
  input  logic                   dither_en,
  input  logic [BITWIDTH-1:0]    kin,
  input  logic                   kin_valid,
  output logic                   kin_ready,
  output logic signed [STAGES:0] sd_out,
  output logic [STAGES-1:0]      carry_mon
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t              state, state_nxt;
  logic [1:0]          ord_act, ord_req;
  logic [BITWIDTH-1:0] k_act, acc1, acc2, acc3;
  logic [15:0]         lfsr;
  logic                c2_z1, c3_z1, c3_z2;
  logic                step, clear;
  logic                dith, en2, en3, c1, c2, c3;
  logic [BITWIDTH:0]   s1, s2, s3;
  logic signed [3:0]   y;
  logic [2:0]          c_vec;

  always_comb begin
    ord_req = order_sel;
    if (order_sel == 2'd0)
      ord_req = 2'd1;
    else if (int'(order_sel) > STAGES)
      ord_req = 2'(STAGES);
  end

  always_comb begin
    state_nxt = state;
    step      = 1'b0;
    clear     = 1'b0;
    kin_ready = 1'b1;
    case (state)
      IDLE: if (enable) state_nxt = RUN;
      RUN: begin
        if (!enable)
          state_nxt = IDLE;
        else if (ord_req != ord_act) begin
          // Clearing on entry keeps the accumulators at zero for the whole FLUSH cycle
          state_nxt = FLUSH;
          clear     = 1'b1;
        end else
          step = 1'b1;
      end
      FLUSH: begin
        kin_ready = 1'b0;
        clear     = 1'b1;
        state_nxt = enable ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dith  = lfsr[0] & dither_en;
    en2   = ord_act >= 2'd2;
    en3   = ord_act == 2'd3;
    s1    = {1'b0, acc1} + {1'b0, k_act} + {{BITWIDTH{1'b0}}, dith};
    s2    = {1'b0, acc2} + {1'b0, s1[BITWIDTH-1:0]};
    s3    = {1'b0, acc3} + {1'b0, s2[BITWIDTH-1:0]};
    c1    = s1[BITWIDTH];
    c2    = en2 & s2[BITWIDTH];
    c3    = en3 & s3[BITWIDTH];
    c_vec = {c3, c2, c1};
  end

  // Stage 2 adds its first difference, stage 3 its second difference
  always_comb begin
    y = 4'sd0;
    y = y + $signed({3'b000, c1});
    y = y + $signed({3'b000, c2}) - $signed({3'b000, c2_z1});
    y = y + $signed({3'b000, c3}) - $signed({2'b00, c3_z1, 1'b0}) + $signed({3'b000, c3_z2});
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc1      <= '0;
      acc2      <= '0;
      acc3      <= '0;
      c2_z1     <= 1'b0;
      c3_z1     <= 1'b0;
      c3_z2     <= 1'b0;
      k_act     <= '0;
      sd_out    <= '0;
      carry_mon <= '0;
      lfsr      <= LFSR_SEED;
      ord_act   <= 2'd1;
    end else begin
      sd_out <= '0;
      if (step) begin
        acc1      <= s1[BITWIDTH-1:0];
        acc2      <= en2 ? s2[BITWIDTH-1:0] : '0;
        acc3      <= en3 ? s3[BITWIDTH-1:0] : '0;
        c2_z1     <= c2;
        c3_z1     <= c3;
        c3_z2     <= c3_z1;
        lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        sd_out    <= y[STAGES:0];
        carry_mon <= c_vec[STAGES-1:0];
      end else if (clear) begin
        acc1      <= '0;
        acc2      <= '0;
        acc3      <= '0;
        c2_z1     <= 1'b0;
        c3_z1     <= 1'b0;
        c3_z2     <= 1'b0;
        carry_mon <= '0;
      end
      if (state == FLUSH)
        ord_act <= ord_req;
      if (kin_valid && kin_ready)
        k_act <= kin;
    end
  end

endmodule
